stage_if_prefetch: RTL and testbench

// - Instruction-fetch stage with a prefetch queue: generates sequential PCs and keeps up to
//   MAX_OUT requests in flight on the inst_* bus (responses return in order).
// - Buffers fetched words in a DEPTH-entry FIFO feeding ID through the valid/stall handshake.
// - Handles a redirect (branch/exception) by flushing the queue and discarding stale responses.
// - Reports AdEL (misaligned PC) and interrupt exceptions on the head entry.

---
 rtl/stage_if_prefetch.sv | 119 +++++++++++
 tb/tb_stage_if_prefetch.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stage_if_prefetch.sv
// Instruction-fetch stage: issues sequential PCs with up to MAX_OUT requests in flight,
// buffers returned words in a DEPTH-entry FIFO toward ID, and flushes cleanly on redirect.
module stage_if_prefetch #(
  parameter int          DEPTH    = 4,
  parameter int          MAX_OUT  = 2,
  parameter logic [31:0] RESET_PC = 32'hbfc00000
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        stall_in,
  output logic        valid_out,
  output logic [31:0] pc_out,
  output logic [31:0] instruction,
  output logic        exc_out,
  output logic [4:0]  exccode_out,
  input  logic        intr,
  output logic        inst_req,
  output logic [31:0] inst_addr,
  input  logic [31:0] inst_rdata,
  input  logic        inst_addr_ok,
  input  logic        inst_data_ok,
  output logic [2:0]  status
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [CW-1:0] MAX_C    = CW'(MAX_OUT);
  localparam logic [4:0]    EXC_INT  = 5'h00;
  localparam logic [4:0]    EXC_ADEL = 5'h04;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        adel;
  } entry_t;

  entry_t        fifo_mem [DEPTH];
  logic [31:0]   req_pc_mem [DEPTH];  // addresses of accepted requests, oldest first
  logic [AW-1:0] rd_ptr, wr_ptr, rq_rd_ptr, rq_wr_ptr;
  logic [CW-1:0] count, outstanding, drop, live;
  logic [CW:0]   occupancy;
  logic [31:0]   fetch_pc;
  logic          halted;
  logic          accept, resp_live, adel_push, push, pop;
  entry_t        head, push_entry;

  assign live      = outstanding - drop;
  assign occupancy = {1'b0, count} + {1'b0, live};
  assign head      = fifo_mem[rd_ptr];

  // The bus is held in reset with this block, so no request leaves while resetn is low.
  assign inst_req  = resetn && !redirect && !halted && (fetch_pc[1:0] == 2'b00) &&
                     (outstanding < MAX_C) && (occupancy < {1'b0, DEPTH_C});
  assign inst_addr = fetch_pc;
  assign accept    = inst_req && inst_addr_ok;
  assign resp_live = inst_data_ok && (drop == '0);
  assign adel_push = !redirect && !halted && (fetch_pc[1:0] != 2'b00) &&
                     (live == '0) && (count < DEPTH_C);
  assign push      = !redirect && (resp_live || adel_push);
  assign pop       = !redirect && valid_out && !stall_in;

  // NOTE: give every always_comb output a default first so no latch is inferred.
  always_comb begin
    push_entry = '{pc: req_pc_mem[rq_rd_ptr], inst: inst_rdata, adel: 1'b0};
    if (adel_push) push_entry = '{pc: fetch_pc, inst: 32'h0, adel: 1'b1};
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      fetch_pc    <= RESET_PC;
      halted      <= 1'b0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
      rq_rd_ptr   <= '0;
      rq_wr_ptr   <= '0;
      outstanding <= '0;
      drop        <= '0;
    end else begin
      // The request queue tracks the bus, stale or not, so it never flushes.
      if (inst_data_ok) rq_rd_ptr <= rq_rd_ptr + AW'(1);
      if (accept)       rq_wr_ptr <= rq_wr_ptr + AW'(1);
      outstanding <= outstanding + CW'(accept) - CW'(inst_data_ok);
      if (redirect) begin
        rd_ptr   <= '0;
        wr_ptr   <= '0;
        count    <= '0;
        fetch_pc <= redirect_pc;
        halted   <= 1'b0;
        drop     <= outstanding - CW'(inst_data_ok);
      end else begin
        if (pop)  rd_ptr <= rd_ptr + AW'(1);
        if (push) wr_ptr <= wr_ptr + AW'(1);
        count <= count + CW'(push) - CW'(pop);
        if (accept)    fetch_pc <= fetch_pc + 32'd4;
        if (adel_push) halted   <= 1'b1;
        if (inst_data_ok && (drop != '0)) drop <= drop - CW'(1);
      end
    end
  end

  // NOTE: storage arrays are not reset; pointers and counters alone define which slots are valid.
  always_ff @(posedge clk) begin
    if (push)   fifo_mem[wr_ptr]      <= push_entry;
    if (accept) req_pc_mem[rq_wr_ptr] <= fetch_pc;
  end

  assign valid_out   = (count != '0);
  assign pc_out      = head.pc;
  assign instruction = head.inst;
  assign exc_out     = valid_out && (intr || head.adel);
  assign exccode_out = intr ? EXC_INT : EXC_ADEL;
  assign status      = {halted, count == DEPTH_C, count == '0};

endmodule

// File: tb/tb_stage_if_prefetch.sv
// Bench for stage_if_prefetch: directed vector table, redirect/AdEL/reset sequences,
// and randomized traffic checked against a queue-based model of the fetch stage.
module tb_stage_if_prefetch;
  localparam int          DEPTH    = 4;
  localparam int          MAX_OUT  = 2;
  localparam logic [31:0] RESET_PC = 32'hbfc00000;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        stall_in = 1'b0;
  logic        valid_out;
  logic [31:0] pc_out;
  logic [31:0] instruction;
  logic        exc_out;
  logic [4:0]  exccode_out;
  logic        intr = 1'b0;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic [31:0] inst_rdata = '0;
  logic        inst_addr_ok = 1'b0;
  logic        inst_data_ok = 1'b0;
  logic [2:0]  status;

  stage_if_prefetch #(.DEPTH(DEPTH), .MAX_OUT(MAX_OUT), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .resetn(resetn), .redirect(redirect), .redirect_pc(redirect_pc),
    .stall_in(stall_in), .valid_out(valid_out), .pc_out(pc_out), .instruction(instruction),
    .exc_out(exc_out), .exccode_out(exccode_out), .intr(intr), .inst_req(inst_req),
    .inst_addr(inst_addr), .inst_rdata(inst_rdata), .inst_addr_ok(inst_addr_ok),
    .inst_data_ok(inst_data_ok), .status(status)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] hash(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5a5a_a5a5;
  endfunction

  // Bus responder: in-order queue of accepted addresses (stale ones included).
  logic [31:0] bus_q[$];
  logic        cap_acc;
  logic [31:0] cap_addr;

  // Reference model: the ID-facing queue plus in-flight requests tagged stale on redirect.
  typedef struct { logic [31:0] pc; logic [31:0] inst; logic adel; } fent_t;
  typedef struct { logic [31:0] addr; logic stale; } req_t;
  fent_t       m_fifo[$];
  req_t        m_infl[$];
  logic [31:0] m_pc;
  logic        m_halted;
  logic        model_on = 1'b0;

  function automatic int m_live();
    int n = 0;
    foreach (m_infl[i]) if (!m_infl[i].stale) n++;
    return n;
  endfunction

  function automatic logic m_req(input logic redir);
    return !redir && !m_halted && (m_pc[1:0] == 2'b00) && (m_infl.size() < MAX_OUT) &&
           (m_fifo.size() + m_live() < DEPTH);
  endfunction

  task automatic model_reset();
    m_fifo.delete();
    m_infl.delete();
    m_pc     = RESET_PC;
    m_halted = 1'b0;
  endtask

  task automatic model_checks();
    int   n = m_fifo.size();
    logic er = m_req(redirect);
    check("valid_out", 32'(valid_out), 32'(n != 0));
    if (n != 0) begin
      check("pc_out", pc_out, m_fifo[0].pc);
      check("instruction", instruction, m_fifo[0].inst);
      check("exc_out", 32'(exc_out), 32'(intr || m_fifo[0].adel));
      check("exccode", 32'(exccode_out), intr ? 32'd0 : 32'd4);
    end else begin
      check("exc_out_empty", 32'(exc_out), 32'd0);
    end
    check("inst_req", 32'(inst_req), 32'(er));
    if (er) check("inst_addr", inst_addr, m_pc);
    check("status", 32'(status), 32'({m_halted, n == DEPTH, n == 0}));
  endtask

  task automatic model_update();
    logic er   = m_req(redirect);
    int   live = m_live();
    int   cnt  = m_fifo.size();
    req_t r    = '{addr: 32'h0, stale: 1'b1};
    if (inst_data_ok && m_infl.size() > 0) r = m_infl.pop_front();
    if (redirect) begin
      m_fifo.delete();
      foreach (m_infl[i]) m_infl[i].stale = 1'b1;
      m_pc     = redirect_pc;
      m_halted = 1'b0;
    end else begin
      if (cnt > 0 && !stall_in) void'(m_fifo.pop_front());
      if (inst_data_ok && !r.stale) m_fifo.push_back('{pc: r.addr, inst: inst_rdata, adel: 1'b0});
      if (!m_halted && m_pc[1:0] != 2'b00 && live == 0 && cnt < DEPTH) begin
        m_fifo.push_back('{pc: m_pc, inst: 32'h0, adel: 1'b1});
        m_halted = 1'b1;
      end
      if (er && inst_addr_ok) begin
        m_infl.push_back('{addr: m_pc, stale: 1'b0});
        m_pc = m_pc + 32'd4;
      end
    end
  endtask

  task automatic drive(input logic redir, input logic [31:0] rpc, input logic st,
                       input logic it, input logic aok, input logic dok_en);
    @(negedge clk);
    redirect     = redir;
    redirect_pc  = rpc;
    stall_in     = st;
    intr         = it;
    inst_addr_ok = aok;
    inst_data_ok = dok_en && (bus_q.size() > 0);
    inst_rdata   = inst_data_ok ? hash(bus_q[0]) : $urandom;
    #1;
  endtask

  task automatic finish_cycle();
    cap_acc  = inst_req && inst_addr_ok;
    cap_addr = inst_addr;
    if (model_on) model_update();
    @(posedge clk);
    if (inst_data_ok && bus_q.size() > 0) void'(bus_q.pop_front());
    if (cap_acc) bus_q.push_back(cap_addr);
  endtask

  task automatic cycle(input logic redir, input logic [31:0] rpc, input logic st,
                       input logic it, input logic aok, input logic dok_en);
    drive(redir, rpc, st, it, aok, dok_en);
    if (model_on) model_checks();
    finish_cycle();
  endtask

  task automatic idle_inputs();
    redirect = 1'b0; stall_in = 1'b0; intr = 1'b1;
    inst_addr_ok = 1'b0; inst_data_ok = 1'b0;
    bus_q.delete();
    model_reset();
  endtask

  typedef struct {
    logic stall; logic intr;
    logic valid; logic [31:0] pc;
    logic req;   logic [31:0] addr;
    logic [2:0] status; logic exc;
  } vec_t;
  vec_t vecs[22];

  initial begin
    bit found;
    // Zero-wait bus stream after reset, with a 10-cycle stall starting at cycle 6.
    vecs[0]  = '{1'b0, 1'b1, 1'b0, 32'h0,        1'b1, 32'hbfc00000, 3'b001, 1'b0};
    vecs[1]  = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 32'hbfc00004, 3'b001, 1'b0};
    vecs[2]  = '{1'b0, 1'b0, 1'b1, 32'hbfc00000, 1'b1, 32'hbfc00008, 3'b000, 1'b0};
    vecs[3]  = '{1'b0, 1'b0, 1'b1, 32'hbfc00004, 1'b1, 32'hbfc0000c, 3'b000, 1'b0};
    vecs[4]  = '{1'b0, 1'b1, 1'b1, 32'hbfc00008, 1'b1, 32'hbfc00010, 3'b000, 1'b1};
    vecs[5]  = '{1'b0, 1'b0, 1'b1, 32'hbfc0000c, 1'b1, 32'hbfc00014, 3'b000, 1'b0};
    vecs[6]  = '{1'b1, 1'b0, 1'b1, 32'hbfc00010, 1'b1, 32'hbfc00018, 3'b000, 1'b0};
    vecs[7]  = '{1'b1, 1'b0, 1'b1, 32'hbfc00010, 1'b1, 32'hbfc0001c, 3'b000, 1'b0};
    vecs[8]  = '{1'b1, 1'b0, 1'b1, 32'hbfc00010, 1'b0, 32'h0,        3'b000, 1'b0};
    for (int i = 9; i <= 15; i++)
      vecs[i] = '{1'b1, 1'b0, 1'b1, 32'hbfc00010, 1'b0, 32'h0, 3'b010, 1'b0};
    vecs[16] = '{1'b0, 1'b0, 1'b1, 32'hbfc00010, 1'b0, 32'h0,        3'b010, 1'b0};
    vecs[17] = '{1'b0, 1'b0, 1'b1, 32'hbfc00014, 1'b1, 32'hbfc00020, 3'b000, 1'b0};
    vecs[18] = '{1'b0, 1'b0, 1'b1, 32'hbfc00018, 1'b1, 32'hbfc00024, 3'b000, 1'b0};
    vecs[19] = '{1'b0, 1'b0, 1'b1, 32'hbfc0001c, 1'b1, 32'hbfc00028, 3'b000, 1'b0};
    vecs[20] = '{1'b0, 1'b0, 1'b1, 32'hbfc00020, 1'b1, 32'hbfc0002c, 3'b000, 1'b0};
    vecs[21] = '{1'b0, 1'b0, 1'b1, 32'hbfc00024, 1'b1, 32'hbfc00030, 3'b000, 1'b0};

    // Reset state.
    idle_inputs();
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", 32'(valid_out), 32'd0);
    check("rst_req", 32'(inst_req), 32'd0);
    check("rst_exc", 32'(exc_out), 32'd0);
    check("rst_status", 32'(status), 32'b001);
    #1 resetn = 1'b1;

    foreach (vecs[i]) begin
      drive(1'b0, 32'h0, vecs[i].stall, vecs[i].intr, 1'b1, 1'b1);
      check($sformatf("vec%0d_valid", i), 32'(valid_out), 32'(vecs[i].valid));
      if (vecs[i].valid) begin
        check($sformatf("vec%0d_pc", i), pc_out, vecs[i].pc);
        check($sformatf("vec%0d_inst", i), instruction, hash(vecs[i].pc));
      end
      check($sformatf("vec%0d_req", i), 32'(inst_req), 32'(vecs[i].req));
      if (vecs[i].req) check($sformatf("vec%0d_addr", i), inst_addr, vecs[i].addr);
      check($sformatf("vec%0d_status", i), 32'(status), 32'(vecs[i].status));
      check($sformatf("vec%0d_exc", i), 32'(exc_out), 32'(vecs[i].exc));
      if (vecs[i].exc) check($sformatf("vec%0d_exccode", i), 32'(exccode_out), 32'd0);
      finish_cycle();
    end

    // Asynchronous reset between edges, mid-burst, with intr held high.
    drive(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b1);
    check("pre_arst_exc", 32'(exc_out), 32'd1);
    #1 resetn = 1'b0;
    #1;
    check("arst_valid", 32'(valid_out), 32'd0);
    check("arst_req", 32'(inst_req), 32'd0);
    check("arst_exc", 32'(exc_out), 32'd0);
    check("arst_status", 32'(status), 32'b001);
    idle_inputs();
    @(posedge clk);
    #2 resetn = 1'b1;
    model_on = 1'b1;
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b1);
    check("restart_addr", inst_addr, 32'hbfc00000);
    model_checks();
    finish_cycle();
    repeat (6) cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b1);

    // Redirect with two requests in flight: both responses must be dropped.
    repeat (2) cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0);
    drive(1'b1, 32'h80000100, 1'b0, 1'b0, 1'b1, 1'b0);
    check("redir_no_req", 32'(inst_req), 32'd0);
    model_checks();
    finish_cycle();
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b1);
      model_checks();
      if (valid_out) begin
        found = 1'b1;
        check("redir_first_pc", pc_out, 32'h80000100);
        check("redir_first_inst", instruction, hash(32'h80000100));
      end
      finish_cycle();
    end
    if (!found) check("redir_timeout", 32'd0, 32'd1);

    // Misaligned redirect: one AdEL entry, then fetch stays halted.
    cycle(1'b1, 32'h80000102, 1'b1, 1'b0, 1'b1, 1'b1);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 1'b1);
      model_checks();
      if (valid_out) begin
        found = 1'b1;
        check("adel_pc", pc_out, 32'h80000102);
        check("adel_exc", 32'(exc_out), 32'd1);
        check("adel_code", 32'(exccode_out), 32'd4);
        check("adel_inst", instruction, 32'h0);
        check("adel_status", 32'(status), 32'b100);
      end
      finish_cycle();
    end
    if (!found) check("adel_timeout", 32'd0, 32'd1);
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b1);
      check("halted_no_req", 32'(inst_req), 32'd0);
      model_checks();
      finish_cycle();
    end
    cycle(1'b1, 32'h80000200, 1'b0, 1'b0, 1'b1, 1'b1);

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] rpc = $urandom;
      if ($urandom_range(0, 3) != 0) rpc[1:0] = 2'b00;
      if ($urandom_range(0, 9) == 0) rpc = 32'hfffffff0;
      cycle($urandom_range(0, 99) < 4, rpc, $urandom_range(0, 99) < 35,
            $urandom_range(0, 99) < 10, $urandom_range(0, 99) < 70,
            $urandom_range(0, 99) < 60);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
